// File: rtl/fxmul_arbiter.sv
// Round-robin arbitrated two-stage fixed-point multiplier (Q.8 scale times data, rounded).
// Define FXMUL_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module fxmul_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W_INPUT_A = 8,
    parameter int W_INPUT_B = 32,
    parameter int W_OUTPUT  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*W_INPUT_A-1:0]     req_a,
    input  logic [N_REQ*W_INPUT_B-1:0]     req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(N_REQ)-1:0]       rsp_id,
    output logic [W_OUTPUT-1:0]            rsp_result,
    output logic                           busy
);
    localparam int W_ID = $clog2(N_REQ);

    logic                 s1_valid_reg;
    logic [W_INPUT_A-1:0] s1_a_reg;
    logic [W_INPUT_B-1:0] s1_b_reg;
    logic [W_ID-1:0]      s1_id_reg;
    logic                 s2_valid_reg;
    logic [W_OUTPUT-1:0]  s2_result_reg;
    logic [W_ID-1:0]      s2_id_reg;

    logic [W_INPUT_A-1:0] a_slice [N_REQ];
    logic [W_INPUT_B-1:0] b_slice [N_REQ];
    logic [N_REQ-1:0]     grant;
    logic [W_ID-1:0]      grant_id;
    logic                 grant_any;
    logic                 s1_advance;
    logic                 s1_accept;
    logic                 take;
    logic [31:0]          prod_lo;
    logic [31:0]          rounded;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_slice[gi]   = req_a[gi*W_INPUT_A +: W_INPUT_A];
            assign b_slice[gi]   = req_b[gi*W_INPUT_B +: W_INPUT_B];
            assign req_ready[gi] = grant[gi] & s1_accept & ~rst;
        end
    endgenerate

`ifdef FXMUL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = W_ID'(i);
                grant[i]  = 1'b1;
            end
        end
    end
`else
    logic [W_ID-1:0] last_grant_reg;

    // Search starts just past the last accepted requester and wraps around.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_grant_reg) + off) % N_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant_id   = W_ID'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= W_ID'(N_REQ - 1);
        end else if (take) begin
            last_grant_reg <= grant_id;
        end
    end
`endif

    assign s1_advance = s1_valid_reg & (~s2_valid_reg | rsp_ready);
    assign s1_accept  = ~s1_valid_reg | s1_advance;
    assign take       = grant_any & s1_accept & ~rst;

    // Only the low 32 product bits feed the rounded Q.8 result.
    assign prod_lo = 32'(s1_a_reg) * 32'(s1_b_reg);
    assign rounded = {{8{prod_lo[31]}}, prod_lo[31:8]} + {31'd0, prod_lo[7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_id_reg     <= '0;
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_id_reg     <= '0;
        end else begin
            if (s1_accept) begin
                s1_valid_reg <= take;
                if (take) begin
                    s1_a_reg  <= a_slice[grant_id];
                    s1_b_reg  <= b_slice[grant_id];
                    s1_id_reg <= grant_id;
                end
            end
            if (s1_advance) begin
                s2_valid_reg  <= 1'b1;
                s2_result_reg <= W_OUTPUT'(rounded);
                s2_id_reg     <= s1_id_reg;
            end else if (s2_valid_reg && rsp_ready) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid  = s2_valid_reg;
    assign rsp_result = s2_result_reg;
    assign rsp_id     = s2_id_reg;
    assign busy       = s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_fxmul_arbiter.sv
// Self-checking bench for fxmul_arbiter: directed scenarios plus random traffic
// compared each cycle against an in-order transaction model.
module tb_fxmul_arbiter;
    localparam int N  = 4;
    localparam int WA = 8;
    localparam int WB = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*WA-1:0] req_a;
    logic [N*WB-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_result;
    logic            busy;

    fxmul_arbiter #(.N_REQ(N), .W_INPUT_A(WA), .W_INPUT_B(WB), .W_OUTPUT(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    bit   vis;
    int   ptr;
    int   n_acc;
    int   k;
    logic [31:0] held_res;
    logic [1:0]  held_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [7:0] a, input logic [31:0] b);
        logic [39:0] p;
        int          s;
        p = 40'(a) * 40'(b);
        s = $signed(p[31:0]);
        return 32'(s >>> 8) + 32'(p[7]);
    endfunction

    function automatic logic [N*WA-1:0] rand_a();
        logic [N*WA-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WA +: WA] = WA'($urandom);
        return v;
    endfunction

    function automatic logic [N*WB-1:0] rand_b();
        logic [N*WB-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WB +: WB] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        vis = 1'b0;
        ptr = N - 1;
    endtask

    // One clock cycle: drive at negedge, check combinational/registered outputs, advance model.
    task automatic step(input logic [N-1:0] v, input logic rr,
                        input logic [N*WA-1:0] a_all, input logic [N*WB-1:0] b_all);
        bit         s1occ, done, adv, acc_ok;
        int         g;
        logic [N-1:0] exp_ready;
        ent_t       e;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        req_a     = a_all;
        req_b     = b_all;
        #1;
        s1occ  = (q.size() - int'(vis)) > 0;
        done   = vis && rr;
        adv    = s1occ && (!vis || done);
        acc_ok = !s1occ || adv;
        g = -1;
`ifdef FXMUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (g < 0 && v[i]) g = i;
`else
        for (int off = 1; off <= N; off++) if (g < 0 && v[(ptr + off) % N]) g = (ptr + off) % N;
`endif
        exp_ready = (acc_ok && g >= 0) ? N'(1 << g) : '0;
        check("rsp_valid", 32'(rsp_valid), 32'(vis));
        if (vis) begin
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check("rsp_result", rsp_result, q[0].res);
        end
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (done) void'(q.pop_front());
        vis = adv || (vis && !done);
        if (acc_ok && g >= 0) begin
            e.id  = 2'(g);
            e.res = ref_mul(a_all[g*WA +: WA], b_all[g*WB +: WB]);
            q.push_back(e);
            ptr = g;
        end
    endtask

    task automatic single_op(input logic [7:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input string tag);
        logic [N*WA-1:0] av;
        logic [N*WB-1:0] bv;
        av = rand_a();
        bv = rand_b();
        av[WA-1:0] = a;
        bv[WB-1:0] = b;
        step(4'b0001, 1'b1, av, bv);
        step(4'b0000, 1'b1, rand_a(), rand_b());
        check({tag, "_latency_early"}, 32'(rsp_valid), 32'd0);
        step(4'b0000, 1'b1, rand_a(), rand_b());
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_result"}, rsp_result, exp);
        check({tag, "_id"}, 32'(rsp_id), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // All requesters valid, consumer always ready.
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step(4'b1111, 1'b1, rand_a(), rand_b());
            if (c >= 2) check("stream_valid", 32'(rsp_valid), 32'd1);
`ifndef FXMUL_ARB_FIXED_PRIO_EN
            if (rsp_valid) begin
                check("stream_id_seq", 32'(rsp_id), 32'(k % N));
                k++;
            end
`endif
        end

        // Drain, then back-pressure for five cycles.
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, rand_a(), rand_b());
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b0, rand_a(), rand_b());
            if (req_ready != 0) n_acc++;
            if (c == 2) begin
                held_res = rsp_result;
                held_id  = rsp_id;
            end
            if (c > 2) begin
                check("stall_hold_result", rsp_result, held_res);
                check("stall_hold_id", 32'(rsp_id), 32'(held_id));
            end
        end
        check("stall_accepts", 32'(n_acc), 32'd2);
        check("stall_ready_low", 32'(req_ready), 32'd0);
        for (int c = 0; c < 6; c++) step(4'b1111, 1'b1, rand_a(), rand_b());

        // Fill both stages, then reset mid-cycle.
        step(4'b1111, 1'b0, rand_a(), rand_b());
        step(4'b1111, 1'b0, rand_a(), rand_b());
        check("prefill_busy", 32'(busy), 32'd1);
        check("prefill_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_result", rsp_result, 32'd0);
        model_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        step(4'b1111, 1'b1, rand_a(), rand_b());
        check("post_rst_first_grant", 32'(req_ready), 32'd1);
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, rand_a(), rand_b());

        single_op(8'h80, 32'h0000_0100, 32'h0000_0080, "basic");
        single_op(8'h01, 32'h0000_0080, 32'h0000_0001, "round");
        single_op(8'h02, 32'h4000_0000, 32'hFF80_0000, "signext");

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0), rand_a(), rand_b());
        end
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b1, rand_a(), rand_b());
        check("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fxmul_arbiter.md
FXMUL_ARBITER -- requirements
Module: fxmul_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter W_INPUT_A, default 8, giving the width of the scale operand.
REQ-003 The block SHALL have parameter W_INPUT_B, default 32, giving the width of the data operand.
REQ-004 The block SHALL have parameter W_OUTPUT, default 32, giving the width of the result.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, N_REQ bits: per-requester operand valid.
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: per-requester accept; at most one bit is high per cycle.
REQ-009 The block SHALL have port req_a, input, N_REQ*W_INPUT_A bits: the scale operand of requester i, in slice i.
REQ-010 The block SHALL have port req_b, input, N_REQ*W_INPUT_B bits: the data operand of requester i, in slice i.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port rsp_id, output, clog2(N_REQ) bits: index of the requester that owns the result.
REQ-014 The block SHALL have port rsp_result, output, W_OUTPUT bits: the fixed-point product.
REQ-015 The block SHALL have port busy, output, 1 bit: high while any pipeline stage holds a valid entry.

Function
REQ-016 An operand transfer SHALL occur on a cycle where req_valid[i] and req_ready[i] are both high; a result transfer SHALL occur on a cycle where rsp_valid and rsp_ready are both high.
REQ-017 The pipeline SHALL have two stages: S1 (operand register holding a, b and id) and S2 (result register holding the result and id).
REQ-018 S1 SHALL accept a transfer when S1 is empty, or when S1 advances into S2 in the same cycle.
REQ-019 S1 SHALL advance into S2 when S2 is empty, or when S2 completes a result transfer in the same cycle.
REQ-020 req_ready[i] SHALL equal grant[i] AND the S1 accept condition; req_ready may depend combinationally on req_valid and rsp_ready.
REQ-021 The arbiter SHALL be round-robin: the grant goes to the first valid requester after last_grant, searching cyclically upward.
REQ-022 last_grant SHALL update only on an accepted transfer; a grant that is not accepted SHALL NOT move the pointer.
REQ-023 Latency SHALL be 2 cycles from operand acceptance to rsp_valid, with throughput of one result per cycle while rsp_ready is high.
REQ-024 Arithmetic SHALL form p = unsigned(a) * unsigned(b), 40 bits.
REQ-025 rsp_result SHALL equal {8 copies of p[31], p[31:8]} + p[7], taken modulo 2^32; the sum wraps silently.
REQ-026 While rsp_valid is high and rsp_ready is low, rsp_result and rsp_id SHALL hold stable.
REQ-027 At most two operations SHALL be in flight at any time.
REQ-028 A requester SHALL NOT be starved: each valid requester is granted within N_REQ accepted transfers.
REQ-029 busy SHALL equal S1_valid OR S2_valid.

Reset
REQ-030 On rst assertion, S1 and S2 SHALL be invalidated immediately and asynchronously, discarding in-flight operations.
REQ-031 On rst assertion, rsp_valid, req_ready and busy SHALL go to 0.
REQ-032 On rst assertion, rsp_result and rsp_id SHALL go to 0.
REQ-033 On rst assertion, last_grant SHALL be set to N_REQ-1, so requester 0 has first priority.
REQ-034 On the first clock edge after rst deasserts, the block SHALL be able to accept a transfer.

Configuration
REQ-035 When macro FXMUL_ARB_FIXED_PRIO_EN is defined, the arbiter SHALL be fixed-priority: the lowest valid index wins, and last_grant SHALL be removed.
REQ-036 When FXMUL_ARB_FIXED_PRIO_EN is not defined, the arbiter SHALL be round-robin as in REQ-021 and REQ-022.

Verification
REQ-037 Scenario: req0 sends a=0x80, b=0x00000100 -> rsp_result=0x00000080 and rsp_id=0, with rsp_valid 2 cycles after acceptance.
REQ-038 Scenario: a=0x01, b=0x00000080 -> rsp_result=0x00000001 (rounding bit p[7] added).
REQ-039 Scenario: a=0x02, b=0x40000000 -> rsp_result=0xFF800000 (sign extension from p[31]).
REQ-040 Scenario: all 4 requesters continuously valid, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1..., one result per cycle.
REQ-041 Scenario: as REQ-040 but rsp_ready=0 for 5 cycles -> exactly 2 accepts, then req_ready=0 and rsp_result/rsp_id stable; resumes without loss or duplication.
REQ-042 Scenario: rst pulsed while S1 and S2 are full -> rsp_valid=0 and busy=0 immediately; with FXMUL_ARB_FIXED_PRIO_EN defined and all requesters valid, only id 0 is served.
